pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_hazard_detect.sv | 17 +
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MC_TIMEOUT_DEF = 64;
  localparam int         WDOG_W         = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard comparator between the EX load and the ID sources.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
               ((ex_rd == id_rs) || (ex_rd == id_rt));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with multi-cycle ALU wait and watchdog abort.
// Optional stalled-cycle counter built when PIPE_CTRL_PERF_EN is defined.
//   state   | meaning
//   RUN     | normal issue; resolves branch flush, multi-cycle entry, load-use stall
//   MC_WAIT | front end frozen until mc_done or watchdog timeout
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mc_start,
  input  logic             mc_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             mc_err,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MC_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                load_use;

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .load_use    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    mc_err      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (mc_start) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_en = 1'b0;
          wdog_d  = '0;
          state_d = MC_WAIT;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MC_WAIT: begin
        pc_en   = mc_done;
        ifid_en = mc_done;
        idex_en = mc_done;
        if (mc_done) begin
          wdog_d  = '0;
          state_d = RUN;
        end else if (wdog_q == WDOG_LAST) begin
          // Abort: release the front end and squash the unfinished op.
          mc_err      = 1'b1;
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          idex_bubble = 1'b1;
          wdog_d      = '0;
          state_d     = RUN;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  assign busy = (state_q == MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default-timeout instance plus a MC_TIMEOUT=4 instance.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        ex_mem_read, branch_taken, mc_start, mc_done;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, mc_err, busy;
  logic [15:0] stall_cnt;
  logic        t_pc_en, t_ifid_en, t_ifid_flush, t_idex_en, t_idex_bubble, t_mc_err, t_busy;
  logic [15:0] t_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mc_start(mc_start),
    .mc_done(mc_done), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_bubble(idex_bubble), .mc_err(mc_err), .busy(busy),
    .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.MC_TIMEOUT(4)) u_to (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mc_start(mc_start),
    .mc_done(mc_done), .pc_en(t_pc_en), .ifid_en(t_ifid_en), .ifid_flush(t_ifid_flush),
    .idex_en(t_idex_en), .idex_bubble(t_idex_bubble), .mc_err(t_mc_err), .busy(t_busy),
    .stall_cnt(t_stall_cnt)
  );

  // Packed order: pc_en ifid_en ifid_flush idex_en idex_bubble mc_err busy
  wire [6:0] ctl   = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, mc_err, busy};
  wire [6:0] t_ctl = {t_pc_en, t_ifid_en, t_ifid_flush, t_idex_en, t_idex_bubble, t_mc_err, t_busy};

  localparam logic [6:0] C_RUN    = 7'b1101000;
  localparam logic [6:0] C_LU     = 7'b0001100;
  localparam logic [6:0] C_BR     = 7'b1111100;
  localparam logic [6:0] C_MCSTRT = 7'b0000000;
  localparam logic [6:0] C_WAIT   = 7'b0000001;
  localparam logic [6:0] C_DONE   = 7'b1101001;
  localparam logic [6:0] C_TMO    = 7'b1101111;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    cyc();
  endtask

  function automatic logic [15:0] perf(input int n);
`ifdef PIPE_CTRL_PERF_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    quiet();
    rst_n = 1'b0;
    #2;
    chk("reset_ctl", 16'(ctl), 16'(C_RUN));
    chk("reset_stall", stall_cnt, 16'd0);
    #10;
    rst_n = 1'b1;
    cyc();

    // Load-use on rs: one stall cycle, then free-running.
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; #1;
    chk("lu_rs", 16'(ctl), 16'(C_LU));
    cyc();
    ex_mem_read = 1'b0; #1;
    chk("lu_after", 16'(ctl), 16'(C_RUN));
    chk("lu_stall_cnt", stall_cnt, perf(1));

    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd5; id_rt = 5'd3; #1;
    chk("lu_rt", 16'(ctl), 16'(C_LU));
    cyc();

    ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
    chk("lu_r0", 16'(ctl), 16'(C_RUN));
    ex_mem_read = 1'b0; ex_rd = 5'd9; id_rs = 5'd9; #1;
    chk("no_load", 16'(ctl), 16'(C_RUN));
    ex_mem_read = 1'b1; id_rs = 5'd4; id_rt = 5'd7; #1;
    chk("lu_nomatch", 16'(ctl), 16'(C_RUN));

    // Branch beats mc_start and load-use.
    branch_taken = 1'b1; mc_start = 1'b1; id_rs = 5'd9; #1;
    chk("branch_prio", 16'(ctl), 16'(C_BR));
    cyc();
    quiet(); #1;
    chk("branch_stays_run", 16'(ctl), 16'(C_RUN));
    mc_done = 1'b1; #1;
    chk("done_in_run", 16'(ctl), 16'(C_RUN));
    cyc();
    mc_done = 1'b0;
    chk("stall_before_mc", stall_cnt, perf(2));

    // Multi-cycle op completing on the 5th MC_WAIT cycle.
    mc_start = 1'b1; #1;
    chk("mc_enter", 16'(ctl), 16'(C_MCSTRT));
    cyc();
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd6; id_rs = 5'd6;
      end else begin
        branch_taken = 1'b0; ex_mem_read = 1'b0;
      end
      #1;
      chk($sformatf("mc_wait%0d", i), 16'(ctl), 16'(C_WAIT));
      cyc();
    end
    quiet(); mc_start = 1'b1; mc_done = 1'b1; #1;
    chk("mc_done", 16'(ctl), 16'(C_DONE));
    cyc();
    quiet(); #1;
    chk("mc_back_run", 16'(ctl), 16'(C_RUN));
    // 2 load-use stalls + RUN entry cycle + 4 waiting cycles
    chk("mc_stall_cnt", stall_cnt, perf(7));

    // Watchdog on the MC_TIMEOUT=4 instance.
    do_reset();
    mc_start = 1'b1; #1;
    chk("to_enter", 16'(t_ctl), 16'(C_MCSTRT));
    cyc();
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("to_wait%0d", i), 16'(t_ctl), 16'(C_WAIT));
      cyc();
    end
    #1;
    chk("to_abort", 16'(t_ctl), 16'(C_TMO));
    cyc();
    mc_start = 1'b0; #1;
    chk("to_after", 16'(t_ctl), 16'(C_RUN));
    cyc();

    // mc_done on the timeout cycle wins.
    mc_start = 1'b1;
    cyc();
    mc_start = 1'b0;
    for (int i = 1; i <= 3; i++) cyc();
    mc_done = 1'b1; #1;
    chk("to_done_wins", 16'(t_ctl), 16'(C_DONE));
    cyc();
    mc_done = 1'b0; #1;
    chk("to_done_after", 16'(t_ctl), 16'(C_RUN));

    // Reset mid-wait aborts with no error and clears the counter.
    do_reset();
    mc_start = 1'b1;
    cyc();
    mc_start = 1'b0; #1;
    chk("rst_pre_wait", 16'(ctl), 16'(C_WAIT));
    cyc();
    rst_n = 1'b0; #1;
    chk("rst_mid_ctl", 16'(ctl), 16'(C_RUN));
    chk("rst_mid_stall", stall_cnt, 16'd0);
    cyc();
    rst_n = 1'b1; #1;
    chk("rst_release", 16'(ctl), 16'(C_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
